// File: rtl/apb3_pkg.sv
// Shared definitions for the APB3 master bridge: FSM states, parameter defaults
// and the slot bases of the 4-slot APB3 interconnect memory map.
package apb3_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int          DEF_APB_DWIDTH = 32;
  localparam logic [31:0] DEF_BASE_ADDR  = 32'h7000_0000;
  localparam logic [31:0] DEF_WIN_MASK   = 32'hF000_0000;

  // Slot bases as decoded by the interconnect; kept in step with the software map.
  localparam logic [31:0] SLOT0_BASE = 32'h7000_0000;
  localparam logic [31:0] SLOT1_BASE = 32'h7100_0000;
  localparam logic [31:0] SLOT2_BASE = 32'h7200_0000;
  localparam logic [31:0] SLOT3_BASE = 32'h7300_0000;

endpackage

// File: rtl/apb3_master_bridge.sv
// Turns single-outstanding core load/store requests into APB3 transfers and
// returns read data plus slave/decode/timeout error status.
module apb3_master_bridge
  import apb3_pkg::*;
#(
  parameter int          APB_DWIDTH     = DEF_APB_DWIDTH,
  parameter logic [31:0] BASE_ADDR      = DEF_BASE_ADDR,
  parameter logic [31:0] WIN_MASK       = DEF_WIN_MASK,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic                  req_write,
  input  logic [APB_DWIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [APB_DWIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [31:0]           PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_DWIDTH-1:0] PWDATA,
  input  logic [APB_DWIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam bit             TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam int             CW       = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};

  apb_state_e            state_r;
  apb_state_e            state_nxt_s;
  logic [CW-1:0]         cnt_r;
  logic                  psel_r;
  logic                  penable_r;
  logic                  pwrite_r;
  logic [31:0]           paddr_r;
  logic [APB_DWIDTH-1:0] pwdata_r;
  logic                  rsp_valid_r;
  logic [APB_DWIDTH-1:0] rsp_rdata_r;
  logic                  rsp_err_r;
  logic                  rsp_timeout_r;
  logic                  addr_ok_s;
  logic                  timeout_hit_s;

  assign addr_ok_s     = ((req_addr & WIN_MASK) == BASE_ADDR) && (req_addr[1:0] == 2'b00);
  assign timeout_hit_s = TO_EN && (cnt_r == CNT_LAST);

  // Next-state decode; PREADY wins over a timeout landing on the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_nxt_s = addr_ok_s ? SETUP : RESP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP:  state_nxt_s = ACCESS;
      ACCESS: begin
        if (PREADY || timeout_hit_s) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, APB outputs, wait counter and response registers.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_r       <= IDLE;
      cnt_r         <= {CW{1'b0}};
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      pwrite_r      <= 1'b0;
      paddr_r       <= 32'h0000_0000;
      pwdata_r      <= {APB_DWIDTH{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {APB_DWIDTH{1'b0}};
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      psel_r      <= (state_nxt_s == SETUP) || (state_nxt_s == ACCESS);
      penable_r   <= (state_nxt_s == ACCESS);
      rsp_valid_r <= (state_nxt_s == RESP);

      if (state_r == ACCESS) begin
        if (cnt_r != CNT_MAX) cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= {CW{1'b0}};
      end

      case (state_r)
        IDLE: begin
          if (req_valid) begin
            paddr_r  <= req_addr;
            pwrite_r <= req_write;
            pwdata_r <= req_write ? req_wdata : {APB_DWIDTH{1'b0}};
            if (!addr_ok_s) begin
              rsp_rdata_r   <= {APB_DWIDTH{1'b0}};
              rsp_err_r     <= 1'b1;
              rsp_timeout_r <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_rdata_r   <= (pwrite_r || PSLVERR) ? {APB_DWIDTH{1'b0}} : PRDATA;
            rsp_err_r     <= PSLVERR;
            rsp_timeout_r <= 1'b0;
          end else if (timeout_hit_s) begin
            rsp_rdata_r   <= {APB_DWIDTH{1'b0}};
            rsp_err_r     <= 1'b1;
            rsp_timeout_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = (state_r == IDLE);
  assign PSEL        = psel_r;
  assign PENABLE     = penable_r;
  assign PWRITE      = pwrite_r;
  assign PADDR       = paddr_r;
  assign PWDATA      = pwdata_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_err     = rsp_err_r;
  assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Directed bench for apb3_master_bridge with TIMEOUT_CYCLES=4; inputs change and
// outputs are sampled 1 time unit after each rising PCLK edge.
module tb_apb3_master_bridge;

  logic        PCLK;
  logic        PRESETN;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  apb3_master_bridge #(
    .APB_DWIDTH    (32),
    .BASE_ADDR     (32'h7000_0000),
    .WIN_MASK      (32'hF000_0000),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK       (PCLK),
    .PRESETN    (PRESETN),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s.%s: observed %h expected %h", tag, field, obs, exp);
    end
  endtask

  // One request; PREADY rises on ACCESS cycle index ready_after (0-based).
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wd, input int ready_after, input logic slverr,
                         input logic [31:0] prd, input int exp_psel, input int exp_pen,
                         input int exp_lat, input logic [31:0] exp_rdata,
                         input logic exp_err, input logic exp_to);
    int   lat;
    int   psel_cyc;
    int   pen_cyc;
    int   acc;
    logic got;
    logic stable_ok;
    chk(tag, "req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    req_wdata = wd;
    PRDATA    = prd;
    PSLVERR   = slverr;
    PREADY    = 1'b0;
    tick();
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_BEEF;
    req_wdata = 32'h0BAD_0BAD;
    req_write = ~wr;
    lat = 1; psel_cyc = 0; pen_cyc = 0; acc = 0; got = 1'b0; stable_ok = 1'b1;
    while (!got && lat <= 40) begin
      if (PSEL) begin
        psel_cyc++;
        if (PADDR !== addr || PWRITE !== wr || PWDATA !== (wr ? wd : 32'h0)) stable_ok = 1'b0;
      end
      if (PENABLE) begin
        pen_cyc++;
        if (!PSEL) stable_ok = 1'b0;
      end
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        if (PENABLE) begin
          PREADY = (acc == ready_after);
          acc++;
        end else begin
          PREADY = 1'b0;
        end
        tick();
        lat++;
      end
    end
    chk(tag, "latency", 32'(lat), 32'(exp_lat));
    chk(tag, "psel_cycles", 32'(psel_cyc), 32'(exp_psel));
    chk(tag, "penable_cycles", 32'(pen_cyc), 32'(exp_pen));
    chk(tag, "apb_stable", 32'(stable_ok), 32'd1);
    chk(tag, "rsp_rdata", rsp_rdata, exp_rdata);
    chk(tag, "rsp_err", 32'(rsp_err), 32'(exp_err));
    chk(tag, "rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    chk(tag, "psel_in_resp", 32'(PSEL), 32'd0);
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    tick();
    chk(tag, "rsp_valid_one_cycle", 32'(rsp_valid), 32'd0);
    chk(tag, "rsp_rdata_hold", rsp_rdata, exp_rdata);
    chk(tag, "rsp_err_hold", 32'(rsp_err), 32'(exp_err));
  endtask

  initial begin
    logic saw_rsp;
    PRESETN   = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_write = 1'b0;
    req_wdata = 32'h0;
    PRDATA    = 32'h0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    repeat (2) tick();
    chk("reset", "PSEL", 32'(PSEL), 32'd0);
    chk("reset", "PENABLE", 32'(PENABLE), 32'd0);
    chk("reset", "PWRITE", 32'(PWRITE), 32'd0);
    chk("reset", "PADDR", PADDR, 32'h0);
    chk("reset", "PWDATA", PWDATA, 32'h0);
    chk("reset", "rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset", "rsp_rdata", rsp_rdata, 32'h0);
    chk("reset", "rsp_err", 32'(rsp_err), 32'd0);
    chk("reset", "rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("reset", "req_ready", 32'(req_ready), 32'd1);
    PRESETN = 1'b1;
    tick();

    run_txn("rd_zero_wait", 32'h7000_0010, 1'b0, 32'h0,         0,   1'b0, 32'hCAFE_F00D, 2, 1, 3, 32'hCAFE_F00D, 1'b0, 1'b0);
    run_txn("wr_3_waits",   32'h7100_0004, 1'b1, 32'h1234_5678, 3,   1'b0, 32'h5555_AAAA, 5, 4, 6, 32'h0,         1'b0, 1'b0);
    run_txn("slave_err",    32'h7200_0008, 1'b0, 32'h0,         0,   1'b1, 32'h0,         2, 1, 3, 32'h0,         1'b1, 1'b0);
    run_txn("decode_err",   32'h8000_0000, 1'b0, 32'h0,         0,   1'b0, 32'h7777_7777, 0, 0, 1, 32'h0,         1'b1, 1'b0);
    run_txn("align_err",    32'h7000_0002, 1'b1, 32'hFFFF_0000, 0,   1'b0, 32'h7777_7777, 0, 0, 1, 32'h0,         1'b1, 1'b0);
    run_txn("timeout",      32'h7300_000C, 1'b0, 32'h0,         100, 1'b0, 32'h9999_9999, 5, 4, 6, 32'h0,         1'b1, 1'b1);
    run_txn("ready_on_4th", 32'h7000_0014, 1'b0, 32'h0,         3,   1'b0, 32'h0A0B_0C0D, 5, 4, 6, 32'h0A0B_0C0D, 1'b0, 1'b0);

    // Asynchronous reset while the transfer sits in ACCESS
    req_valid = 1'b1;
    req_addr  = 32'h7000_0020;
    req_write = 1'b0;
    PREADY    = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_reset", "penable_before", 32'(PENABLE), 32'd1);
    #2 PRESETN = 1'b0;
    #1;
    chk("mid_reset", "PSEL_async", 32'(PSEL), 32'd0);
    chk("mid_reset", "PENABLE_async", 32'(PENABLE), 32'd0);
    chk("mid_reset", "req_ready_in_reset", 32'(req_ready), 32'd1);
    #3 PRESETN = 1'b1;
    saw_rsp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid) saw_rsp = 1'b1;
    end
    chk("mid_reset", "no_rsp_valid", 32'(saw_rsp), 32'd0);
    chk("mid_reset", "PSEL_after", 32'(PSEL), 32'd0);

    run_txn("after_reset", 32'h7000_0000, 1'b0, 32'h0, 0, 1'b0, 32'h600D_CAFE, 2, 1, 3, 32'h600D_CAFE, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb3_master_bridge.md
Name: apb3_master_bridge

Overview:
- Converts the RISC-V core's single-outstanding load/store request interface into APB3 master transactions.
- Its PADDR/PSEL/PENABLE/PWRITE/PWDATA outputs drive the master port of the 4-slot APB3 interconnect, which decodes the address into slots 0-3.
- Returns read data, slave error, decode error and timeout status to the core. Word accesses only; one transaction in flight.

Parameters:
- APB_DWIDTH, 32, data width of PWDATA/PRDATA and the core data path.
- BASE_ADDR, 32'h7000_0000, base of the APB window.
- WIN_MASK, 32'hF000_0000, address bits compared against BASE_ADDR to decide the request is in the window.
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles waiting for PREADY; 0 disables the timeout.

Ports:
- PCLK  in  1  clock
- PRESETN  in  1  asynchronous active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  bridge accepts request this cycle
- req_addr  in  32  byte address
- req_write  in  1  1 = write, 0 = read
- req_wdata  in  APB_DWIDTH  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  APB_DWIDTH  read data; 0 for writes and errors
- rsp_err  out  1  error: slave error, decode error or timeout
- rsp_timeout  out  1  error cause was a timeout
- PADDR  out  32  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  APB_DWIDTH  APB write data
- PRDATA  in  APB_DWIDTH  read data from the interconnect
- PREADY  in  1  ready from the interconnect
- PSLVERR  in  1  slave error from the interconnect

Behaviour:
- Clock and reset: one clock, PCLK. Reset PRESETN is asynchronous and active-low. All flops clear immediately on PRESETN low.
- Reset values: state IDLE. PSEL, PENABLE, PWRITE, rsp_valid, rsp_err and rsp_timeout are 0. PADDR, PWDATA and rsp_rdata are 0. req_ready is 1, because it is decoded from IDLE.
- States are IDLE, SETUP, ACCESS and RESP. req_ready = (state==IDLE); it has no combinational path from req_valid.
- IDLE, on req_valid:
  - Register req_addr into PADDR, req_write into PWRITE and req_wdata into PWDATA. PWDATA is 0 on reads.
  - If ((req_addr & WIN_MASK) != BASE_ADDR) or req_addr[1:0] != 0: go to RESP with rsp_err=1 and rsp_timeout=0. PSEL is never asserted.
  - Otherwise go to SETUP.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Cycle counter starts at 0 on entry and increments each cycle.
  - If PREADY=1: capture PRDATA (reads only; writes give 0) and PSLVERR into rsp_rdata/rsp_err. Drop PSEL and PENABLE on the next edge and go to RESP.
  - Else if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: abandon the transfer. Drop PSEL and PENABLE, go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 on the timeout cycle takes priority: normal completion.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. The core has no backpressure. rsp_rdata/rsp_err/rsp_timeout hold their values until the next RESP.
- APB stability: PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS. PENABLE is never 1 while PSEL is 0.
- Latency:
  - Zero-wait slave: request accepted at edge N, SETUP in cycle N+1, ACCESS in N+2, rsp_valid in N+3.
  - Each wait state adds 1 cycle.
  - Decode or alignment error: rsp_valid in N+1.
- Back-to-back: the earliest next acceptance is the cycle after RESP, so there is a minimum of 4 cycles per zero-wait transfer.
- Counter width is clog2(TIMEOUT_CYCLES+1) bits and it saturates; it never wraps.
- Reset mid-transaction: PSEL and PENABLE drop asynchronously and no response is issued. The core must reissue the request.

Decomposition:
- Shared package apb3_pkg holds:
  - state enum {IDLE, SETUP, ACCESS, RESP};
  - APB_DWIDTH default;
  - BASE_ADDR/WIN_MASK defaults;
  - slot base constants SLOT0..SLOT3_BASE shared with the software memory map.
- Single module. The timeout counter is inline; no sub-module is warranted.

Test Plan:
- Read, zero-wait: req_addr=0x7000_0010, PRDATA=0xCAFE_F00D, PREADY=1 -> PSEL 2 cycles, PENABLE 1 cycle, rsp_valid 3 cycles after accept, rsp_rdata=0xCAFE_F00D, rsp_err=0.
- Write, 3 wait states: req_addr=0x7100_0004, wdata=0x1234_5678, PREADY low for 3 ACCESS cycles -> PADDR/PWDATA/PWRITE=1 stable for all 5 PSEL cycles, rsp_valid at accept+6, rsp_rdata=0.
- Slave error: PSLVERR=1 with PREADY=1 -> rsp_err=1, rsp_timeout=0.
- Decode/alignment: req_addr=0x8000_0000, then 0x7000_0002 -> no PSEL, rsp_valid at accept+1, rsp_err=1 each time.
- Timeout: TIMEOUT_CYCLES=4, PREADY held 0 -> exactly 4 ACCESS cycles, then PSEL=0, rsp_err=1, rsp_timeout=1. A second run with PREADY=1 on the 4th cycle completes normally.
- Reset mid-ACCESS: PRESETN low asynchronously between edges -> PSEL/PENABLE go 0 immediately, no rsp_valid, req_ready=1 after release.
